// File: rtl/fft_dspa_pkg.sv
// Shared Q1.12 constants and helpers for the DSPA FFT datapath.
package fft_dspa_pkg;

  localparam int Q_FRAC     = 12;
  localparam int TW_ONE     = 1 << Q_FRAC;
  localparam int ROUND_HALF = TW_ONE >> 1;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cmult_q12.sv
// Complex multiply by a Q1.12 twiddle: registered products, then add/sub,
// round half-up and wrap to DATA_W. conj=1 rotates by c+js instead of c-js.
module cmult_q12 import fft_dspa_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int TW_W   = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_prod,
  input  logic                     ld_out,
  input  logic                     conj,
  input  logic signed [DATA_W-1:0] xr,
  input  logic signed [DATA_W-1:0] xi,
  input  logic signed [TW_W-1:0]   c,
  input  logic signed [TW_W-1:0]   s,
  output logic signed [DATA_W-1:0] yr,
  output logic signed [DATA_W-1:0] yi
);

  localparam int PW = DATA_W + TW_W;
  localparam int SW = PW + 1;

  logic signed [PW-1:0] p_rc, p_is, p_ic, p_rs;
  logic signed [SW-1:0] sum_re, sum_im, rnd_re, rnd_im;

  // ROM data is only meaningful alongside a valid S1 sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_rc <= '0;
      p_is <= '0;
      p_ic <= '0;
      p_rs <= '0;
    end else if (ld_prod) begin
      p_rc <= PW'(xr) * PW'(c);
      p_is <= PW'(xi) * PW'(s);
      p_ic <= PW'(xi) * PW'(c);
      p_rs <= PW'(xr) * PW'(s);
    end
  end

  always_comb begin
    sum_re = '0;
    sum_im = '0;
    if (conj) begin
      sum_re = SW'(p_rc) - SW'(p_is);
      sum_im = SW'(p_ic) + SW'(p_rs);
    end else begin
      sum_re = SW'(p_rc) + SW'(p_is);
      sum_im = SW'(p_ic) - SW'(p_rs);
    end
    rnd_re = sum_re + SW'(ROUND_HALF);
    rnd_im = sum_im + SW'(ROUND_HALF);
  end

  // Truncation to DATA_W wraps on overflow; no saturation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      yr <= '0;
      yi <= '0;
    end else if (ld_out) begin
      yr <= DATA_W'(rnd_re >>> Q_FRAC);
      yi <= DATA_W'(rnd_im >>> Q_FRAC);
    end
  end

endmodule

// File: rtl/fft_twiddle_rotator.sv
// Streaming twiddle-multiply stage: frame counter drives the twiddle ROM, the
// 1-cycle ROM read lines up with S1, result after 3 cycles. TW_CONJ_EN selects IFFT twiddles.
module fft_twiddle_rotator import fft_dspa_pkg::*; #(
  parameter int N            = 256,
  parameter int SIZE         = clog2(N),
  parameter int bit_width_tw = 14,
  parameter int DATA_W       = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic                           in_sof,
  input  logic signed [DATA_W-1:0]       in_re,
  input  logic signed [DATA_W-1:0]       in_im,
  output logic [SIZE-2:0]                rd_ptr_angle,
  output logic                           rom_en,
  input  logic signed [bit_width_tw-1:0] cos_data,
  input  logic signed [bit_width_tw-1:0] sin_data,
  output logic                           out_valid,
  output logic                           out_last,
  output logic signed [DATA_W-1:0]       out_re,
  output logic signed [DATA_W-1:0]       out_im,
  output logic                           sof_err
);

  localparam int STAGES = 3;

`ifdef TW_CONJ_EN
  localparam logic CONJ = 1'b1;
`else
  localparam logic CONJ = 1'b0;
`endif

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } smp_t;

  logic [SIZE-1:0]   cnt, k;
  logic [STAGES:1]   vld_pipe, last_pipe;
  logic              sof_hit;
  smp_t              s1;

  assign sof_hit      = in_valid & in_sof;
  assign k            = sof_hit ? '0 : cnt;
  assign rd_ptr_angle = k[SIZE-2:0];
  assign rom_en       = in_valid;

  // A stray sof mid-frame is flagged but still restarts the frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      vld_pipe  <= '0;
      last_pipe <= '0;
      sof_err   <= 1'b0;
    end else begin
      if (in_valid) cnt <= k + SIZE'(1);
      vld_pipe  <= {vld_pipe[STAGES-1:1], in_valid};
      last_pipe <= {last_pipe[STAGES-1:1], in_valid && (k == SIZE'(N - 1))};
      sof_err   <= sof_hit && (cnt != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           s1 <= '0;
    else if (in_valid) s1 <= '{re: in_re, im: in_im};
  end

  cmult_q12 #(
    .DATA_W (DATA_W),
    .TW_W   (bit_width_tw)
  ) u_cmult (
    .clk     (clk),
    .rst     (rst),
    .ld_prod (vld_pipe[1]),
    .ld_out  (vld_pipe[2]),
    .conj    (CONJ),
    .xr      (s1.re),
    .xi      (s1.im),
    .c       (cos_data),
    .s       (sin_data),
    .yr      (out_re),
    .yi      (out_im)
  );

  assign out_valid = vld_pipe[STAGES];
  assign out_last  = last_pipe[STAGES];

endmodule

// File: tb/tb_fft_twiddle_rotator.sv
// Randomized bench for fft_twiddle_rotator with a registered twiddle ROM model
// and an arithmetic reference model / scoreboard.
module tb_fft_twiddle_rotator;

  logic               clk;
  logic               rst;
  logic               in_valid, in_sof;
  logic signed [15:0] in_re, in_im;
  logic [6:0]         rd_ptr_angle;
  logic               rom_en;
  logic signed [13:0] cos_data, sin_data;
  logic               out_valid, out_last, sof_err;
  logic signed [15:0] out_re, out_im;

  fft_twiddle_rotator #(.N(256), .SIZE(8), .bit_width_tw(14), .DATA_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_sof       (in_sof),
    .in_re        (in_re),
    .in_im        (in_im),
    .rd_ptr_angle (rd_ptr_angle),
    .rom_en       (rom_en),
    .cos_data     (cos_data),
    .sin_data     (sin_data),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .out_re       (out_re),
    .out_im       (out_im),
    .sof_err      (sof_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cos_tab [128];
  int sin_tab [128];

  always @(posedge clk) begin
    if (rom_en) begin
      cos_data <= 14'(cos_tab[rd_ptr_angle]);
      sin_data <= 14'(sin_tab[rd_ptr_angle]);
    end
  end

  typedef struct {
    int     due;
    longint re;
    longint im;
    bit     last;
  } exp_t;

  exp_t   q[$];
  bit     exp_sof[int];
  longint obs_re[$], obs_im[$];
  int     cyc = 0;
  int     m_cnt;
  int     n_chk = 0, n_pass = 0;
  int     n_last, n_sof;
  longint hold_re, hold_im;
  bit     started;
  exp_t   e;
  bit     ev;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic longint wrap16(input longint v);
    logic signed [15:0] t;
    t = v[15:0];
    return longint'(t);
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
    end
  endtask

  task automatic send(input bit sof, input int re, input int im);
    int     k;
    longint xr, xi, c, s, sr, si;
    @(negedge clk);
    in_valid = 1'b1;
    in_sof   = sof;
    in_re    = 16'(re);
    in_im    = 16'(im);
    k = sof ? 0 : m_cnt;
    #1;
    chk("rd_ptr_angle", rd_ptr_angle, k % 128);
    chk("rom_en", rom_en, 1);
    if (sof && m_cnt != 0) exp_sof[cyc + 1] = 1'b1;
    xr = longint'(in_re);
    xi = longint'(in_im);
    c  = cos_tab[k % 128];
    s  = sin_tab[k % 128];
`ifdef TW_CONJ_EN
    sr = xr * c - xi * s;
    si = xi * c + xr * s;
`else
    sr = xr * c + xi * s;
    si = xi * c - xr * s;
`endif
    q.push_back('{cyc + 3, wrap16((sr + 2048) >>> 12), wrap16((si + 2048) >>> 12), k == 255});
    m_cnt = (k + 1) % 256;
  endtask

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // Scoreboard: every cycle compares valid timing, data, hold behaviour and sof_err
  always @(negedge clk) begin
    if (!rst && started) begin
      ev = (q.size() > 0) && (q[0].due == cyc);
      chk("out_valid", out_valid, ev);
      if (ev) begin
        e = q.pop_front();
        chk("out_re", out_re, e.re);
        chk("out_im", out_im, e.im);
        chk("out_last", out_last, e.last);
        hold_re = e.re;
        hold_im = e.im;
        obs_re.push_back(out_re);
        obs_im.push_back(out_im);
      end else begin
        chk("hold_re", out_re, hold_re);
        chk("hold_im", out_im, hold_im);
      end
      if (out_last) n_last++;
      if (sof_err) n_sof++;
      chk("sof_err", sof_err, exp_sof.exists(cyc));
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_re = '0; in_im = '0;
    m_cnt = 0; started = 1'b0; hold_re = 0; hold_im = 0; n_last = 0; n_sof = 0;
    for (int i = 0; i < 128; i++) begin
      cos_tab[i] = int'($urandom_range(0, 8191)) - 4096;
      sin_tab[i] = int'($urandom_range(0, 8191)) - 4096;
    end
    cos_tab[0] = 4096; sin_tab[0] = 0;
    cos_tab[1] = 3895; sin_tab[1] = 1265;
    cos_tab[2] = 2048; sin_tab[2] = 2048;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_sof_err", sof_err, 0);
    chk("rst_out_re", out_re, 0);
    chk("rst_out_im", out_im, 0);
    chk("rst_rd_ptr", rd_ptr_angle, 0);
    chk("rst_rom_en", rom_en, 0);
    @(negedge clk);
    rst = 1'b0;
    started = 1'b1;
    idle(2);

    // Frame A: directed samples then back-to-back random
    n_last = 0;
    obs_re.delete(); obs_im.delete();
    send(1, 1000, 0);
    send(0, 4096, 0);
    send(0, 3, 3);
    for (int i = 0; i < 253; i++) send(0, rnd16(), rnd16());
    idle(6);
    chk("ex1_re", obs_re[0], 1000);
    chk("ex1_im", obs_im[0], 0);
    chk("ex2_re", obs_re[1], 3895);
`ifdef TW_CONJ_EN
    chk("ex2_im", obs_im[1], 1265);
    chk("ex3_re", obs_re[2], 0);
    chk("ex3_im", obs_im[2], 3);
`else
    chk("ex2_im", obs_im[1], -1265);
    chk("ex3_re", obs_re[2], 3);
    chk("ex3_im", obs_im[2], 0);
`endif
    chk("frameA_last_cnt", n_last, 1);

    // Frame B: random gaps
    n_last = 0;
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
      send(i == 0, rnd16(), rnd16());
    end
    idle(6);
    chk("frameB_last_cnt", n_last, 1);

    // Frame C: premature sof at k=17 restarts the frame
    n_last = 0;
    n_sof  = 0;
    for (int i = 0; i < 17; i++) send(i == 0, rnd16(), rnd16());
    send(1, rnd16(), rnd16());
    for (int i = 0; i < 255; i++) send(0, rnd16(), rnd16());
    idle(6);
    chk("frameC_sof_err_cnt", n_sof, 1);
    chk("frameC_last_cnt", n_last, 1);

    // Reset with two samples in flight
    send(1, rnd16(), rnd16());
    send(0, rnd16(), rnd16());
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    in_sof = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_sof_err", sof_err, 0);
    chk("mid_rst_out_re", out_re, 0);
    chk("mid_rst_out_im", out_im, 0);
    q.delete();
    exp_sof.delete();
    m_cnt = 0;
    hold_re = 0;
    hold_im = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(6);

    // Restart after reset
    for (int i = 0; i < 5; i++) send(i == 0, rnd16(), rnd16());
    idle(6);
    chk("drain_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
